tnn_seq_classifier: RTL and testbench
=====================================

TNN_SEQ_CLASSIFIER -- requirements
Module: tnn_seq_classifier

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 12: number of input features.
REQ-002 SHALL have parameter HIDDEN_CNT, default 40: number of hidden neurons.
REQ-003 SHALL have parameter CLASS_CNT, default 6: number of output classes (>=2).
REQ-004 SHALL have parameter FEAT_BITS, default 4: unsigned width of each feature.
REQ-005 SHALL have parameter W1, default all-zero, width 2*FEAT_CNT*HIDDEN_CNT: layer-1 ternary weights; weight (h,f) at bits [2*(h*FEAT_CNT+f)+:2].
REQ-006 SHALL have parameter W2, default all-zero, width 2*HIDDEN_CNT*CLASS_CNT: layer-2 ternary weights; weight (c,h) at bits [2*(c*HIDDEN_CNT+h)+:2].
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port in_valid  input  1  data holds a valid sample.
REQ-010 SHALL have port in_ready  output  1  block can accept a sample.
REQ-011 SHALL have port data  input  FEAT_BITS*FEAT_CNT  features; feature 0 in LSBs.
REQ-012 SHALL have port out_valid  output  1  prediction is valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes prediction.
REQ-014 SHALL have port prediction  output  $clog2(CLASS_CNT)  winning class index.

Function
REQ-015 SHALL decode ternary weights: 2'b01=+1, 2'b11=-1, 2'b00 and 2'b10=0.
REQ-016 SHALL implement FSM IDLE -> L1 -> L2 -> ARG -> DONE -> IDLE.
REQ-017 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready, register data internally, clear all accumulators, enter L1.
REQ-018 SHALL in L1 process one feature per cycle, f=0..FEAT_CNT-1, adding w1(h,f)*x_f to signed acc_h for all h in parallel; exactly FEAT_CNT cycles.
REQ-019 SHALL size acc_h signed, $clog2(FEAT_CNT*(2**FEAT_BITS-1)+1)+1 bits; no overflow possible.
REQ-020 SHALL on leaving L1 latch hidden[h] = 1 iff acc_h >= 0.
REQ-021 SHALL in L2 process one hidden neuron per cycle, h=0..HIDDEN_CNT-1, adding w2(c,h) to signed score_c when hidden[h]=1; exactly HIDDEN_CNT cycles; score width $clog2(HIDDEN_CNT+1)+1.
REQ-022 SHALL in ARG scan one class per cycle, c=0..CLASS_CNT-1, replacing best only on strictly greater score (ties -> lowest index); exactly CLASS_CNT cycles.
REQ-023 SHALL assert out_valid exactly FEAT_CNT+HIDDEN_CNT+CLASS_CNT+1 rising edges after the accepting edge (59 at defaults).
REQ-024 SHALL hold out_valid and prediction stable in DONE until out_valid && out_ready, then go IDLE next cycle.
REQ-025 SHALL ignore data and in_valid changes outside the accepting edge.
REQ-026 SHALL hold prediction at last result after handshake until next DONE.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter IDLE, clear out_valid=0, prediction=0, counters, accumulators, hidden; in_ready=1 the following cycle.
REQ-028 SHALL abort any in-flight inference on reset with no output produced; rst has priority over all handshakes.

Structure
REQ-029 SHALL place ternary encoding constants, weight-decode function and FSM state enum in shared package tnn_pkg.
REQ-030 SHALL use one sub-module tnn_tern_acc (ternary-weighted signed accumulator lane with clear/enable), instantiated per hidden neuron and per class.

Verification
REQ-031 All-zero W1/W2, any data -> hidden all 1, scores 0, prediction=0, out_valid after 59 edges (defaults).
REQ-032 FEAT_CNT=2,HIDDEN_CNT=2,CLASS_CNT=3,FEAT_BITS=4; W1 h0=(+1,-1),h1=(-1,+1); W2 c2=(+1,+1), others 0; data x0=9,x1=3 -> hidden=01 (h0=1,h1=0), prediction=2, out_valid 8 edges after accept.
REQ-033 out_ready held low 10 cycles in DONE -> out_valid, prediction stable, in_ready=0 throughout; accept next sample only after handshake+1 cycle.
REQ-034 rst pulsed during L2 -> next cycle out_valid=0, prediction=0, in_ready=1; new sample then completes with full latency.
REQ-035 Equal top scores at classes 1 and 4 -> prediction=1.
REQ-036 100 back-to-back samples with in_valid held high, out_ready=1 -> results match golden model in order, one per FEAT_CNT+HIDDEN_CNT+CLASS_CNT+3 cycles.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary sequential classifier.
// Contents:
//   - ternary weight encodings
//   - weight-decode function
//   - controller state enum
package tnn_pkg;

    // Ternary weight encodings. 2'b10 is also treated as zero.
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    typedef enum logic [1:0] {
        TV_ZERO,
        TV_POS,
        TV_NEG
    } tern_val_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_ARG,
        ST_DONE
    } tnn_state_e;

    // Map a 2-bit ternary code onto its arithmetic meaning.
    function automatic tern_val_e tern_decode(input logic [1:0] w);
        tern_val_e v;
        case (w)
            TERN_POS:  v = TV_POS;
            TERN_NEG:  v = TV_NEG;
            TERN_ZERO: v = TV_ZERO;
            default:   v = TV_ZERO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tnn_tern_acc.sv
// Ternary-weighted signed accumulator lane.
// Each enabled cycle adds +x, -x or nothing according to the ternary weight w.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       zero the accumulator (takes precedence over en)
//   en        accumulate this cycle
//   w         2-bit ternary weight code
//   x         unsigned operand
//   sum_c     value the accumulator holds after the coming edge (combinational)
module tnn_tern_acc
    import tnn_pkg::*;
#(
    parameter int unsigned ACC_BITS = 8,
    parameter int unsigned X_BITS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic [1:0]                 w,
    input  logic [X_BITS-1:0]          x,
    output logic signed [ACC_BITS-1:0] sum_c
);

    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] x_ext;

    // Zero-extend the unsigned operand into the signed accumulator width.
    assign x_ext = ACC_BITS'({1'b0, x});

    // Next accumulator value; exposed so the owner can act on the final sum
    // in the same cycle the last term is added.
    always_comb begin
        sum_c = acc;
        if (clr) begin
            sum_c = '0;
        end else if (en) begin
            case (tern_decode(w))
                TV_POS:  sum_c = acc + x_ext;
                TV_NEG:  sum_c = acc - x_ext;
                default: sum_c = acc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/tnn_seq_classifier.sv
// Two-layer ternary neural-network classifier, evaluated sequentially.
// Layer 1 streams one feature per cycle into HIDDEN_CNT parallel lanes.
// Layer 2 streams one binarised hidden neuron per cycle into CLASS_CNT lanes.
// An argmax scan then picks the winning class, lowest index on ties.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     sample handshake; data carries FEAT_CNT features, feature 0 in LSBs
//   out_valid/out_ready   result handshake; prediction is the winning class index
module tnn_seq_classifier
    import tnn_pkg::*;
#(
    parameter int unsigned FEAT_CNT   = 12,
    parameter int unsigned HIDDEN_CNT = 40,
    parameter int unsigned CLASS_CNT  = 6,
    parameter int unsigned FEAT_BITS  = 4,
    parameter logic [2*FEAT_CNT*HIDDEN_CNT-1:0]  W1 = '0,
    parameter logic [2*HIDDEN_CNT*CLASS_CNT-1:0] W2 = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS*FEAT_CNT-1:0] data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  prediction
);

    localparam int unsigned PRED_BITS  = $clog2(CLASS_CNT);
    localparam int unsigned ACC_BITS   = $clog2(FEAT_CNT*(2**FEAT_BITS-1)+1) + 1;
    localparam int unsigned SCORE_BITS = $clog2(HIDDEN_CNT+1) + 1;
    localparam int unsigned MAX_CNT    = (FEAT_CNT > HIDDEN_CNT) ?
                                         ((FEAT_CNT > CLASS_CNT) ? FEAT_CNT : CLASS_CNT) :
                                         ((HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT);
    localparam int unsigned CNT_BITS   = $clog2(MAX_CNT+1);

    tnn_state_e                   state;
    logic [CNT_BITS-1:0]          cnt;
    logic [FEAT_BITS*FEAT_CNT-1:0] data_q;
    logic [HIDDEN_CNT-1:0]        hidden;
    logic signed [SCORE_BITS-1:0] best_score;
    logic [PRED_BITS-1:0]         best_idx;

    logic                         accept_c;
    logic                         l1_en_c;
    logic                         l2_en_c;
    logic                         last_c;
    logic [FEAT_BITS-1:0]         feat_c;
    logic                         hbit_c;
    logic signed [SCORE_BITS-1:0] score_sel_c;
    logic [HIDDEN_CNT-1:0]        hid_c;
    logic [CLASS_CNT*SCORE_BITS-1:0] score_flat;

    // Per-cycle operand selection and phase-end detection.
    always_comb begin
        accept_c    = (state == ST_IDLE) && in_valid && in_ready;
        l1_en_c     = (state == ST_L1);
        l2_en_c     = (state == ST_L2);
        feat_c      = FEAT_BITS'(data_q >> (32'(cnt) * FEAT_BITS));
        hbit_c      = 1'(hidden >> cnt);
        score_sel_c = $signed(SCORE_BITS'(score_flat >> (32'(cnt) * SCORE_BITS)));
        last_c      = 1'b0;
        case (state)
            ST_L1:   last_c = (cnt == CNT_BITS'(FEAT_CNT - 1));
            ST_L2:   last_c = (cnt == CNT_BITS'(HIDDEN_CNT - 1));
            ST_ARG:  last_c = (cnt == CNT_BITS'(CLASS_CNT - 1));
            default: last_c = 1'b0;
        endcase
    end

    // Hidden lanes: the sign of the post-edge sum becomes the binary activation,
    // so it can be latched on the same edge that adds the last feature.
    for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_l1
        logic [1:0]                 w;
        logic signed [ACC_BITS-1:0] sum;

        assign w = 2'(W1 >> (2 * (h * FEAT_CNT + 32'(cnt))));

        tnn_tern_acc #(
            .ACC_BITS (ACC_BITS),
            .X_BITS   (FEAT_BITS)
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept_c),
            .en    (l1_en_c),
            .w     (w),
            .x     (feat_c),
            .sum_c (sum)
        );

        assign hid_c[h] = ~sum[ACC_BITS-1];
    end

    // Class lanes: add the weight itself whenever the current hidden bit is set.
    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_l2
        logic [1:0]                   w;
        logic signed [SCORE_BITS-1:0] sum;

        assign w = 2'(W2 >> (2 * (c * HIDDEN_CNT + 32'(cnt))));

        tnn_tern_acc #(
            .ACC_BITS (SCORE_BITS),
            .X_BITS   (1)
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept_c),
            .en    (l2_en_c),
            .w     (w),
            .x     (hbit_c),
            .sum_c (sum)
        );

        // Lanes are idle during the scan, so the post-edge sum equals the held score.
        assign score_flat[c*SCORE_BITS +: SCORE_BITS] = sum;
    end

    // Controller: sequences the phases and owns all handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_q     <= '0;
            hidden     <= '0;
            best_score <= '0;
            best_idx   <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            prediction <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        data_q   <= data;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_L1;
                    end
                end
                ST_L1: begin
                    if (last_c) begin
                        hidden <= hid_c;
                        cnt    <= '0;
                        state  <= ST_L2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_L2: begin
                    if (last_c) begin
                        cnt   <= '0;
                        state <= ST_ARG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ARG: begin
                    // First class seeds the running best; later ones need a strict win.
                    if ((cnt == '0) || (score_sel_c > best_score)) begin
                        best_score <= score_sel_c;
                        best_idx   <= PRED_BITS'(cnt);
                    end
                    if (last_c) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; then wait for the consumer.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        prediction <= best_idx;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_seq_classifier.sv
// Directed testbench for tnn_seq_classifier.
// Four instances share clock, reset and a common handshake bus; sel picks which
// instance the stimulus talks to:
//   0: 2-2-3 network with hand-picked weights
//   1: default size, all-zero weights
//   2: 2-2-6 network with a tie between classes 1 and 4
//   3: default size with pseudo-random weights, checked against a software model
module tb_tnn_seq_classifier;

    localparam int unsigned F = 12;
    localparam int unsigned H = 40;
    localparam int unsigned C = 6;

    // Pseudo-random ternary weight image (LCG), evaluated at elaboration.
    function automatic logic [959:0] gen_w(input int unsigned seed);
        logic [959:0] v;
        int unsigned  s;
        v = '0;
        s = seed;
        for (int i = 0; i < 480; i++) begin
            s = s * 32'd1664525 + 32'd1013904223;
            v[2*i +: 2] = s[25:24];
        end
        return v;
    endfunction

    localparam logic [959:0] W1_G = gen_w(32'd7);
    localparam logic [479:0] W2_G = 480'(gen_w(32'd99));

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  sel;
    logic [47:0] data_bus;

    logic       s_in_ready, s_out_valid;
    logic [1:0] s_pred;
    logic       z_in_ready, z_out_valid;
    logic [2:0] z_pred;
    logic       t_in_ready, t_out_valid;
    logic [2:0] t_pred;
    logic       g_in_ready, g_out_valid;
    logic [2:0] g_pred;

    logic       cur_ready, cur_valid;
    logic [2:0] cur_pred;

    int vecs = 0;
    int errs = 0;

    logic [47:0] samp [100];
    int          expv [100];

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd0:    begin cur_ready = s_in_ready; cur_valid = s_out_valid; cur_pred = {1'b0, s_pred}; end
            2'd1:    begin cur_ready = z_in_ready; cur_valid = z_out_valid; cur_pred = z_pred; end
            2'd2:    begin cur_ready = t_in_ready; cur_valid = t_out_valid; cur_pred = t_pred; end
            default: begin cur_ready = g_in_ready; cur_valid = g_out_valid; cur_pred = g_pred; end
        endcase
    end

    tnn_seq_classifier #(
        .FEAT_CNT(2), .HIDDEN_CNT(2), .CLASS_CNT(3), .FEAT_BITS(4),
        .W1(8'h7D), .W2(12'h500)
    ) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && (sel == 2'd0)), .in_ready(s_in_ready),
        .data(data_bus[7:0]),
        .out_valid(s_out_valid), .out_ready(out_ready && (sel == 2'd0)),
        .prediction(s_pred)
    );

    tnn_seq_classifier dut_z (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && (sel == 2'd1)), .in_ready(z_in_ready),
        .data(data_bus),
        .out_valid(z_out_valid), .out_ready(out_ready && (sel == 2'd1)),
        .prediction(z_pred)
    );

    tnn_seq_classifier #(
        .FEAT_CNT(2), .HIDDEN_CNT(2), .CLASS_CNT(6), .FEAT_BITS(4),
        .W1(8'h00), .W2(24'h05015A)
    ) dut_t (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && (sel == 2'd2)), .in_ready(t_in_ready),
        .data(data_bus[7:0]),
        .out_valid(t_out_valid), .out_ready(out_ready && (sel == 2'd2)),
        .prediction(t_pred)
    );

    tnn_seq_classifier #(
        .W1(W1_G), .W2(W2_G)
    ) dut_g (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && (sel == 2'd3)), .in_ready(g_in_ready),
        .data(data_bus),
        .out_valid(g_out_valid), .out_ready(out_ready && (sel == 2'd3)),
        .prediction(g_pred)
    );

    // Reference network for the default-size instance.
    function automatic int golden(input logic [47:0] d);
        int   acc;
        int   sc [C];
        logic hid [H];
        int   bi;
        for (int h = 0; h < H; h++) begin
            acc = 0;
            for (int f = 0; f < F; f++) begin
                if (W1_G[2*(h*F+f) +: 2] == 2'b01) acc = acc + int'(d[4*f +: 4]);
                else if (W1_G[2*(h*F+f) +: 2] == 2'b11) acc = acc - int'(d[4*f +: 4]);
            end
            hid[h] = (acc >= 0);
        end
        for (int c = 0; c < C; c++) begin
            sc[c] = 0;
            for (int h = 0; h < H; h++) begin
                if (hid[h]) begin
                    if (W2_G[2*(c*H+h) +: 2] == 2'b01) sc[c] = sc[c] + 1;
                    else if (W2_G[2*(c*H+h) +: 2] == 2'b11) sc[c] = sc[c] - 1;
                end
            end
        end
        bi = 0;
        for (int c = 1; c < C; c++) begin
            if (sc[c] > sc[bi]) bi = c;
        end
        return bi;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample, hold it for exactly the accepting edge, then scramble data.
    task automatic send(input logic [47:0] d);
        int n;
        n = 0;
        while (!cur_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", 32'(cur_ready), 32'd1);
        data_bus = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_bus = 48'({$urandom, $urandom});
    endtask

    // Count edges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int n);
        n = 0;
        while (!cur_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        int r;
        int last_acc;
        logic took_in;
        logic took_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 2'd0;
        data_bus  = '0;
        for (int i = 0; i < 100; i++) begin
            samp[i] = 48'({$urandom, $urandom});
            expv[i] = golden(samp[i]);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready", 32'(s_in_ready), 32'd1);
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_pred", 32'(s_pred), 32'd0);

        // Small network: x0=9, x1=3 -> hidden 01, prediction 2, 8-edge latency
        send(48'h39);
        wait_out(lat);
        check("small_latency", 32'(lat), 32'd8);
        check("small_pred", 32'(cur_pred), 32'd2);
        check("small_hidden", 32'(dut_s.hidden), 32'd1);

        // Back-pressure: result and readiness held while out_ready is low
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(cur_valid), 32'd1);
            check("hold_pred", 32'(cur_pred), 32'd2);
            check("hold_in_ready", 32'(cur_ready), 32'd0);
            tick();
        end
        handshake();
        check("post_hs_valid", 32'(cur_valid), 32'd0);
        check("post_hs_ready", 32'(cur_ready), 32'd1);
        check("post_hs_pred", 32'(cur_pred), 32'd2);

        // Reset in the middle of layer 2 aborts; next sample has full latency
        send(48'h39);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(cur_valid), 32'd0);
        check("abort_pred", 32'(cur_pred), 32'd0);
        check("abort_ready", 32'(cur_ready), 32'd1);
        send(48'h44);
        wait_out(lat);
        check("abort_relat", 32'(lat), 32'd8);
        check("abort_repred", 32'(cur_pred), 32'd2);
        check("abort_hidden", 32'(dut_s.hidden), 32'd3);
        handshake();

        // All-zero weights: every hidden neuron fires, all scores tie at 0
        sel = 2'd1;
        send(48'hA5C3_19F0_7E2B);
        wait_out(lat);
        check("zero_latency", 32'(lat), 32'd59);
        check("zero_pred", 32'(cur_pred), 32'd0);
        check("zero_hidden", 32'(&dut_z.hidden), 32'd1);
        handshake();

        // Tie between classes 1 and 4 resolves to the lower index
        sel = 2'd2;
        send(48'h7B);
        wait_out(lat);
        check("tie_latency", 32'(lat), 32'd11);
        check("tie_pred", 32'(cur_pred), 32'd1);
        handshake();

        // 100 back-to-back samples against the software model
        sel       = 2'd3;
        out_ready = 1'b1;
        k         = 0;
        r         = 0;
        last_acc  = -1;
        data_bus  = samp[0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 8000 && r < 100; cyc++) begin
            took_in  = cur_ready && in_valid;
            took_out = cur_valid && out_ready;
            if (took_out) begin
                check("b2b_pred", 32'(cur_pred), 32'(expv[r]));
                r++;
            end
            tick();
            if (took_in) begin
                if (last_acc >= 0) check("b2b_period", 32'(cyc - last_acc), 32'd61);
                last_acc = cyc;
                k++;
                if (k < 100) data_bus = samp[k];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 32'(r), 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
